// File: rtl/vpe_icache_pkg.sv
// vpe_icache_pkg: shared types and helpers for the loadable VPE instruction store.
//   - state_e   : load FSM states (IDLE / LOAD / DONE)
//   - INST_W_DEF, ADDR_W_DEF : default geometry (36-bit words, 256 deep)
//   - even_par  : even-parity bit over a zero-padded data word
package vpe_icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int INST_W_DEF = 36;
  localparam int ADDR_W_DEF = 8;

  // Widest word the parity helper accepts; callers zero-pad into this.
  localparam int PAR_MAX_W = 256;

  // Bit that makes the total number of ones (data + bit) even.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/vpe_icache_ram.sv
// vpe_icache_ram: DEPTH x W distributed RAM, synchronous write, asynchronous read.
// Ports:
//   clk             write clock
//   we/waddr/wdata  write port, committed on rising edge
//   raddr/rdata     combinational read port
// Contents are not reset.
module vpe_icache_ram #(
  parameter int W      = 37,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vpe_icache_ld.sv
// vpe_icache_ld: loadable instruction store for the VPE sequencer.
// A host burst port writes programs into a DEPTH x INST_W RAM; the fetch port
// returns a registered instruction with a one-cycle valid pulse. Fetches are
// refused while a burst is being written.
// Ports:
//   clk, rst                        clock, async active-high reset
//   i_rd_valid/i_rd_addr/o_rd_ready fetch request handshake
//   o_inst/o_inst_valid             registered fetch result
//   i_ld_start/i_ld_base/i_ld_len   burst start, base address, word count
//   i_ld_valid/i_ld_data/o_ld_ready burst data beats
//   o_ld_done                       one-cycle pulse at burst end
//   o_prog_ready                    a complete program is resident
//   o_par_err                       parity mismatch on current o_inst
// Build option: define VPE_ICACHE_PARITY_EN to store an even-parity bit per
// word and add input i_ld_par_inj (flips the stored parity of a beat).
// Without it o_par_err is tied low.
module vpe_icache_ld
  import vpe_icache_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_valid,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ready,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  input  logic              i_ld_start,
  input  logic [ADDR_W-1:0] i_ld_base,
  input  logic [ADDR_W:0]   i_ld_len,
  input  logic              i_ld_valid,
  input  logic [INST_W-1:0] i_ld_data,
`ifdef VPE_ICACHE_PARITY_EN
  input  logic              i_ld_par_inj,
`endif
  output logic              o_ld_ready,
  output logic              o_ld_done,
  output logic              o_prog_ready,
  output logic              o_par_err
);

`ifdef VPE_ICACHE_PARITY_EN
  localparam int MEM_W = INST_W + 1;
`else
  localparam int MEM_W = INST_W;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              prog_ready_q, prog_ready_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              par_err_q, par_err_d;

  logic              we;
  logic              rd_accept;
  logic [MEM_W-1:0]  wr_word, rd_word;

  vpe_icache_ram #(.W(MEM_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (addr_q),
    .wdata (wr_word),
    .raddr (i_rd_addr),
    .rdata (rd_word)
  );

  assign o_rd_ready = (state_q != ST_LOAD);
  assign o_ld_ready = (state_q == ST_LOAD);
  assign o_ld_done  = (state_q == ST_DONE);
  assign rd_accept  = i_rd_valid && o_rd_ready;

  // Load FSM
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    prog_ready_d = prog_ready_q;
    we           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_ld_start) begin
          if (i_ld_len != '0) begin
            addr_d       = i_ld_base;
            rem_d        = i_ld_len;
            prog_ready_d = 1'b0;
            state_d      = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (i_ld_valid) begin
          we     = 1'b1;
          addr_d = addr_q + 1'b1;   // wraps naturally at DEPTH
          rem_d  = rem_q - 1'b1;
          if (rem_q == 1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        prog_ready_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write word formation and fetch path
`ifdef VPE_ICACHE_PARITY_EN
  logic [PAR_MAX_W-1:0] par_wr_in, par_rd_in;
  always_comb begin
    par_wr_in              = '0;
    par_wr_in[INST_W-1:0]  = i_ld_data;
    par_rd_in              = '0;
    par_rd_in[INST_W-1:0]  = rd_word[INST_W-1:0];
    wr_word = {even_par(par_wr_in) ^ i_ld_par_inj, i_ld_data};
  end
`else
  assign wr_word = i_ld_data;
`endif

  always_comb begin
    inst_d       = inst_q;
    inst_valid_d = rd_accept;
    par_err_d    = par_err_q;
    if (rd_accept) begin
      inst_d = rd_word[INST_W-1:0];
`ifdef VPE_ICACHE_PARITY_EN
      par_err_d = even_par(par_rd_in) != rd_word[INST_W];
`else
      par_err_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      prog_ready_q <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      prog_ready_q <= prog_ready_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      par_err_q    <= par_err_d;
    end
  end

  assign o_inst       = inst_q;
  assign o_inst_valid = inst_valid_q;
  assign o_prog_ready = prog_ready_q;
  assign o_par_err    = par_err_q;

endmodule

// File: tb/tb_vpe_icache_ld.sv
// Directed self-checking bench for vpe_icache_ld (default geometry 36 x 256).
module tb_vpe_icache_ld;

  localparam int INST_W = 36;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_rd_valid = 1'b0;
  logic [ADDR_W-1:0] i_rd_addr = '0;
  logic              o_rd_ready;
  logic [INST_W-1:0] o_inst;
  logic              o_inst_valid;
  logic              i_ld_start = 1'b0;
  logic [ADDR_W-1:0] i_ld_base = '0;
  logic [ADDR_W:0]   i_ld_len = '0;
  logic              i_ld_valid = 1'b0;
  logic [INST_W-1:0] i_ld_data = '0;
  logic              i_ld_par_inj = 1'b0;
  logic              o_ld_ready;
  logic              o_ld_done;
  logic              o_prog_ready;
  logic              o_par_err;

  int nvec = 0;
  int nerr = 0;

  logic [INST_W-1:0] a_w [4] = '{36'h0A0A0A0A0, 36'h0A0A0A0A1, 36'h0A0A0A0A2, 36'h0A0A0A0A3};
  logic [INST_W-1:0] b_w [3] = '{36'h9B0000001, 36'h9B0000002, 36'h9B0000003};
  logic [INST_W-1:0] c_w [2] = '{36'h5C5C5C5C0, 36'h5C5C5C5C1};

  vpe_icache_ld #(.INST_W(INST_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rd_valid   (i_rd_valid),
    .i_rd_addr    (i_rd_addr),
    .o_rd_ready   (o_rd_ready),
    .o_inst       (o_inst),
    .o_inst_valid (o_inst_valid),
    .i_ld_start   (i_ld_start),
    .i_ld_base    (i_ld_base),
    .i_ld_len     (i_ld_len),
    .i_ld_valid   (i_ld_valid),
    .i_ld_data    (i_ld_data),
`ifdef VPE_ICACHE_PARITY_EN
    .i_ld_par_inj (i_ld_par_inj),
`endif
    .o_ld_ready   (o_ld_ready),
    .o_ld_done    (o_ld_done),
    .o_prog_ready (o_prog_ready),
    .o_par_err    (o_par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    nvec++; if (o_inst !== '0)        begin nerr++; $display("FAIL rst_inst: got %h exp 0", o_inst); end
    nvec++; if (o_inst_valid !== 1'b0) begin nerr++; $display("FAIL rst_ivld: got %b exp 0", o_inst_valid); end
    nvec++; if (o_ld_ready !== 1'b0)   begin nerr++; $display("FAIL rst_ldrdy: got %b exp 0", o_ld_ready); end
    nvec++; if (o_ld_done !== 1'b0)    begin nerr++; $display("FAIL rst_lddone: got %b exp 0", o_ld_done); end
    nvec++; if (o_prog_ready !== 1'b0) begin nerr++; $display("FAIL rst_prog: got %b exp 0", o_prog_ready); end
    nvec++; if (o_par_err !== 1'b0)    begin nerr++; $display("FAIL rst_par: got %b exp 0", o_par_err); end
    nvec++; if (o_rd_ready !== 1'b1)   begin nerr++; $display("FAIL rst_rdrdy: got %b exp 1", o_rd_ready); end
    rst = 1'b0;
    step();
    i_rd_valid = 1'b1; i_rd_addr = 8'h00;
    step();
    nvec++; if (o_inst_valid !== 1'b1) begin nerr++; $display("FAIL fetch0_vld: got %b exp 1", o_inst_valid); end
    i_rd_valid = 1'b0;
    step();
    nvec++; if (o_inst_valid !== 1'b0) begin nerr++; $display("FAIL fetch0_pulse: got %b exp 0", o_inst_valid); end
  endtask

  task automatic test_load_basic();
    i_ld_start = 1'b1; i_ld_base = 8'h10; i_ld_len = 9'd4;
    step();
    i_ld_start = 1'b0;
    nvec++; if (o_ld_ready !== 1'b1) begin nerr++; $display("FAIL ld_ready: got %b exp 1", o_ld_ready); end
    nvec++; if (o_rd_ready !== 1'b0) begin nerr++; $display("FAIL ld_rdblk: got %b exp 0", o_rd_ready); end
    for (int i = 0; i < 4; i++) begin
      i_ld_valid = 1'b1; i_ld_data = a_w[i];
      step();
      if (i < 3) begin
        nvec++; if (o_ld_done !== 1'b0) begin nerr++; $display("FAIL ld_early_done beat%0d: got %b exp 0", i, o_ld_done); end
      end
    end
    i_ld_valid = 1'b0;
    nvec++; if (o_ld_done !== 1'b1) begin nerr++; $display("FAIL ld_done: got %b exp 1", o_ld_done); end
    step();
    nvec++; if (o_ld_done !== 1'b0)    begin nerr++; $display("FAIL ld_done_pulse: got %b exp 0", o_ld_done); end
    nvec++; if (o_prog_ready !== 1'b1) begin nerr++; $display("FAIL ld_prog: got %b exp 1", o_prog_ready); end
    for (int i = 0; i < 4; i++) begin
      i_rd_valid = 1'b1; i_rd_addr = 8'h10 + 8'(i);
      step();
      nvec++; if (o_inst_valid !== 1'b1) begin nerr++; $display("FAIL rd_vld%0d: got %b exp 1", i, o_inst_valid); end
      nvec++; if (o_inst !== a_w[i])     begin nerr++; $display("FAIL rd_data%0d: got %h exp %h", i, o_inst, a_w[i]); end
    end
    i_rd_valid = 1'b0;
    step();
    nvec++; if (o_inst_valid !== 1'b0) begin nerr++; $display("FAIL rd_idle_vld: got %b exp 0", o_inst_valid); end
    nvec++; if (o_inst !== a_w[3])     begin nerr++; $display("FAIL rd_hold: got %h exp %h", o_inst, a_w[3]); end
  endtask

  task automatic test_wrap();
    i_ld_start = 1'b1; i_ld_base = 8'hFE; i_ld_len = 9'd3;
    step();
    i_ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_ld_valid = 1'b1; i_ld_data = b_w[i];
      step();
    end
    i_ld_valid = 1'b0;
    nvec++; if (o_ld_done !== 1'b1) begin nerr++; $display("FAIL wrap_done: got %b exp 1", o_ld_done); end
    // fetch issued in the DONE cycle sees the freshly written wrap word
    i_rd_valid = 1'b1; i_rd_addr = 8'h00;
    step();
    nvec++; if (o_inst !== b_w[2]) begin nerr++; $display("FAIL wrap_00: got %h exp %h", o_inst, b_w[2]); end
    i_rd_addr = 8'hFE;
    step();
    nvec++; if (o_inst !== b_w[0]) begin nerr++; $display("FAIL wrap_fe: got %h exp %h", o_inst, b_w[0]); end
    i_rd_addr = 8'hFF;
    step();
    nvec++; if (o_inst !== b_w[1]) begin nerr++; $display("FAIL wrap_ff: got %h exp %h", o_inst, b_w[1]); end
    i_rd_addr = 8'h10;
    step();
    nvec++; if (o_inst !== a_w[0]) begin nerr++; $display("FAIL wrap_keep10: got %h exp %h", o_inst, a_w[0]); end
    i_rd_valid = 1'b0;
    step();
  endtask

  task automatic test_stall_reset();
    i_ld_start = 1'b1; i_ld_base = 8'h20; i_ld_len = 9'd4;
    step();
    i_ld_start = 1'b0;
    nvec++; if (o_prog_ready !== 1'b0) begin nerr++; $display("FAIL sr_prog_clr: got %b exp 0", o_prog_ready); end
    i_rd_valid = 1'b1; i_rd_addr = 8'h10;
    nvec++; if (o_rd_ready !== 1'b0) begin nerr++; $display("FAIL sr_rdrdy: got %b exp 0", o_rd_ready); end
    // beat, gap, beat, gap: fetch held high throughout must never complete
    for (int i = 0; i < 4; i++) begin
      i_ld_valid = (i % 2 == 0); i_ld_data = c_w[i/2];
      step();
      nvec++; if (o_inst_valid !== 1'b0) begin nerr++; $display("FAIL sr_ivld%0d: got %b exp 0", i, o_inst_valid); end
      nvec++; if (o_ld_ready !== 1'b1)   begin nerr++; $display("FAIL sr_ldrdy%0d: got %b exp 1", i, o_ld_ready); end
    end
    i_ld_valid = 1'b0; i_rd_valid = 1'b0;
    rst = 1'b1;
    #1;
    nvec++; if (o_prog_ready !== 1'b0) begin nerr++; $display("FAIL sr_rst_prog: got %b exp 0", o_prog_ready); end
    nvec++; if (o_ld_ready !== 1'b0)   begin nerr++; $display("FAIL sr_rst_ldrdy: got %b exp 0", o_ld_ready); end
    nvec++; if (o_rd_ready !== 1'b1)   begin nerr++; $display("FAIL sr_rst_rdrdy: got %b exp 1", o_rd_ready); end
    #2;
    rst = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      i_rd_valid = 1'b1; i_rd_addr = 8'h20 + 8'(i);
      step();
      nvec++; if (o_inst !== c_w[i]) begin nerr++; $display("FAIL sr_keep%0d: got %h exp %h", i, o_inst, c_w[i]); end
    end
    i_rd_valid = 1'b0;
    step();
  endtask

  task automatic test_len0();
    i_ld_start = 1'b1; i_ld_base = 8'h10; i_ld_len = 9'd0;
    i_ld_valid = 1'b1; i_ld_data = 36'hFFFFFFFFF;
    step();
    i_ld_start = 1'b0;
    nvec++; if (o_ld_done !== 1'b1)  begin nerr++; $display("FAIL l0_done: got %b exp 1", o_ld_done); end
    nvec++; if (o_ld_ready !== 1'b0) begin nerr++; $display("FAIL l0_ldrdy: got %b exp 0", o_ld_ready); end
    step();
    i_ld_valid = 1'b0;
    nvec++; if (o_prog_ready !== 1'b1) begin nerr++; $display("FAIL l0_prog: got %b exp 1", o_prog_ready); end
    i_rd_valid = 1'b1; i_rd_addr = 8'h10;
    step();
    nvec++; if (o_inst !== a_w[0]) begin nerr++; $display("FAIL l0_mem: got %h exp %h", o_inst, a_w[0]); end
    i_rd_valid = 1'b0;
    step();
  endtask

  task automatic test_start_fetch();
    // start and fetch in the same IDLE cycle: fetch wins this cycle
    i_ld_start = 1'b1; i_ld_base = 8'h30; i_ld_len = 9'd1;
    i_rd_valid = 1'b1; i_rd_addr = 8'h11;
    step();
    i_ld_start = 1'b0; i_rd_valid = 1'b0;
    nvec++; if (o_inst_valid !== 1'b1) begin nerr++; $display("FAIL sf_vld: got %b exp 1", o_inst_valid); end
    nvec++; if (o_inst !== a_w[1])     begin nerr++; $display("FAIL sf_data: got %h exp %h", o_inst, a_w[1]); end
    nvec++; if (o_ld_ready !== 1'b1)   begin nerr++; $display("FAIL sf_ldrdy: got %b exp 1", o_ld_ready); end
    i_ld_valid = 1'b1; i_ld_data = 36'h123456789;
    step();
    i_ld_valid = 1'b0;
    nvec++; if (o_ld_done !== 1'b1) begin nerr++; $display("FAIL sf_done: got %b exp 1", o_ld_done); end
    step();
  endtask

  task automatic test_parity();
    i_ld_start = 1'b1; i_ld_base = 8'h05; i_ld_len = 9'd2;
    step();
    i_ld_start = 1'b0;
    i_ld_valid = 1'b1; i_ld_data = 36'h000000007; i_ld_par_inj = 1'b1;
    step();
    i_ld_data = 36'h000000003; i_ld_par_inj = 1'b0;
    step();
    i_ld_valid = 1'b0;
    step();
    i_rd_valid = 1'b1; i_rd_addr = 8'h05;
    step();
    nvec++; if (o_inst_valid !== 1'b1) begin nerr++; $display("FAIL par5_vld: got %b exp 1", o_inst_valid); end
`ifdef VPE_ICACHE_PARITY_EN
    nvec++; if (o_par_err !== 1'b1) begin nerr++; $display("FAIL par5_err: got %b exp 1", o_par_err); end
`else
    nvec++; if (o_par_err !== 1'b0) begin nerr++; $display("FAIL par5_off: got %b exp 0", o_par_err); end
`endif
    i_rd_addr = 8'h06;
    step();
    nvec++; if (o_par_err !== 1'b0)          begin nerr++; $display("FAIL par6_err: got %b exp 0", o_par_err); end
    nvec++; if (o_inst !== 36'h000000003)    begin nerr++; $display("FAIL par6_data: got %h exp 000000003", o_inst); end
    i_rd_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_wrap();
    test_stall_reset();
    test_len0();
    test_start_fetch();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
